// File: rtl/rst_sequencer.sv
// Reset sequencer: debounced button, software and watchdog triggers drive a
// HOLD/RELEASE/RUN FSM that releases N_OUT active-low resets in index order.
module rst_sequencer #(
    parameter int N_OUT           = 2,
    parameter int POR_CYCLES      = 8388608,
    parameter int STAGE_GAP       = 16,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int WDT_CYCLES      = 0
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             btn_n,
    input  logic             soft_rst_req,
    input  logic             wdt_kick,
    output logic [N_OUT-1:0] rst_out_n,
    output logic             busy,
    output logic [1:0]       cause
);
    localparam int CNT_MAX = (POR_CYCLES > STAGE_GAP) ? POR_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WDT_MAX = (WDT_CYCLES > 0) ? WDT_CYCLES : 1;
    localparam int WDT_W   = $clog2(WDT_MAX + 1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    state_t           state, state_next;
    logic [1:0]       sync;
    logic             deb;
    logic [DB_W-1:0]  db_cnt;
    logic [CNT_W-1:0] cnt;
    logic [WDT_W-1:0] wdt_cnt;
    logic [1:0]       cause_next;
    logic [N_OUT-1:0] rel_next;
    logic             btn_trig, wdt_trig, soft_trig, any_trig;
    logic             hold_done, gap_done;

    // The button trigger is the cycle whose edge flips the debounced level low.
    assign btn_trig  = deb && !sync[1] && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign wdt_trig  = (WDT_CYCLES > 0) && (state == RUN) && !wdt_kick
                       && (wdt_cnt == WDT_W'(WDT_MAX - 1));
    assign soft_trig = (state == RUN) && soft_rst_req;
    assign any_trig  = btn_trig || wdt_trig || soft_trig;

    assign hold_done = (state == HOLD) && deb && (cnt == CNT_W'(POR_CYCLES - 1));
    assign gap_done  = (state == RELEASE) && (cnt == CNT_W'(STAGE_GAP - 1));
    // Outputs form a thermometer code, so releasing the next bit is a shift-in of one.
    assign rel_next  = (rst_out_n << 1) | N_OUT'(1);

    // NOTE: rst_n is sampled only at the clock edge, so it sits inside the posedge-only block.
    always_ff @(posedge CLK) begin
        if (!rst_n) state <= HOLD;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_next = state;
        cause_next = cause;
        if (btn_trig)       cause_next = CAUSE_BTN;
        else if (wdt_trig)  cause_next = CAUSE_WDT;
        else if (soft_trig) cause_next = CAUSE_SOFT;

        if (any_trig) begin
            state_next = HOLD;
        end else begin
            case (state)
                HOLD:    if (hold_done) state_next = (&rel_next) ? RUN : RELEASE;
                RELEASE: if (gap_done && (&rel_next)) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = HOLD;
            endcase
        end
    end

    always_comb begin
        busy = ~&rst_out_n;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sync      <= 2'b11;
            deb       <= 1'b1;
            db_cnt    <= '0;
            cnt       <= '0;
            wdt_cnt   <= '0;
            rst_out_n <= '0;
            cause     <= CAUSE_POR;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            sync <= {sync[0], btn_n};

            if (sync[1] == deb) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb    <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (any_trig) begin
                rst_out_n <= '0;
                cnt       <= '0;
                cause     <= cause_next;
            end else begin
                case (state)
                    HOLD: begin
                        if (!deb) begin
                            cnt <= '0;
                        end else if (hold_done) begin
                            rst_out_n <= rel_next;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (gap_done) begin
                            rst_out_n <= rel_next;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end

            if ((WDT_CYCLES > 0) && (state == RUN) && !any_trig && !wdt_kick)
                wdt_cnt <= wdt_cnt + 1'b1;
            else
                wdt_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_rst_sequencer.sv
// Randomised bench for rst_sequencer: a timestamp-based reference model predicts
// every cycle's outputs into a queue that a negedge monitor drains and compares.
module tb_rst_sequencer;
    localparam int N_OUT           = 3;
    localparam int POR_CYCLES      = 8;
    localparam int STAGE_GAP       = 4;
    localparam int DEBOUNCE_CYCLES = 5;
    localparam int WDT_CYCLES      = 20;
    localparam int LAST_REL        = POR_CYCLES + STAGE_GAP * (N_OUT - 1);

    logic             CLK = 1'b0;
    logic             rst_n = 1'b0;
    logic             btn_n = 1'b1;
    logic             soft_rst_req = 1'b0;
    logic             wdt_kick = 1'b0;
    logic [N_OUT-1:0] rst_out_n;
    logic             busy;
    logic [1:0]       cause;

    typedef struct {
        logic [N_OUT-1:0] outs;
        logic             busy;
        logic [1:0]       cause;
        int               edge_no;
    } expect_t;

    expect_t exp_q[$];
    int      vectors     = 0;
    int      miscompares = 0;

    // Reference model state: edges are counted from 1; *_ref are edge stamps.
    int       edge_no  = 0;
    int       hold_ref = 0;
    int       wdt_ref  = 0;
    int       run_len  = 0;
    bit       deb_m    = 1'b1;
    bit       in_run   = 1'b0;
    bit       auto_kick = 1'b0;
    logic [1:0] cause_m = 2'd0;
    bit       rst_h1 = 1'b0, rst_h2 = 1'b0;
    bit       btn_h1 = 1'b1, btn_h2 = 1'b1;

    always #5 CLK = ~CLK;

    rst_sequencer #(
        .N_OUT(N_OUT), .POR_CYCLES(POR_CYCLES), .STAGE_GAP(STAGE_GAP),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .WDT_CYCLES(WDT_CYCLES)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .btn_n(btn_n), .soft_rst_req(soft_rst_req),
        .wdt_kick(wdt_kick), .rst_out_n(rst_out_n), .busy(busy), .cause(cause)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Predicts the outputs after one edge from the inputs sampled at that edge.
    task automatic model_edge(input bit r, input bit b, input bit s, input bit kk);
        bit      samp, deb_prev, fall, wdt_fire, soft_fire;
        int      el;
        expect_t e;
        edge_no++;
        // The debouncer sees the button two edges late, forced high around reset.
        samp = (rst_h1 && rst_h2) ? btn_h2 : 1'b1;
        rst_h2 = rst_h1; rst_h1 = r;
        btn_h2 = btn_h1; btn_h1 = b;
        if (!r) begin
            hold_ref = edge_no;
            cause_m  = 2'd0;
            deb_m    = 1'b1;
            run_len  = 0;
            in_run   = 1'b0;
        end else begin
            deb_prev = deb_m;
            fall     = 1'b0;
            if (samp != deb_m) begin
                run_len++;
                if (run_len == DEBOUNCE_CYCLES) begin
                    deb_m   = samp;
                    run_len = 0;
                    fall    = !samp;
                end
            end else begin
                run_len = 0;
            end
            wdt_fire  = in_run && !kk && (edge_no - wdt_ref == WDT_CYCLES);
            soft_fire = in_run && s;
            if (fall || wdt_fire || soft_fire) begin
                cause_m  = fall ? 2'd1 : (wdt_fire ? 2'd3 : 2'd2);
                hold_ref = edge_no;
                in_run   = 1'b0;
            end else if (!deb_prev) begin
                hold_ref = edge_no;
            end else if (in_run && kk) begin
                wdt_ref = edge_no;
            end
            if (!in_run && (edge_no - hold_ref == LAST_REL)) begin
                in_run  = 1'b1;
                wdt_ref = edge_no;
            end
        end
        el = edge_no - hold_ref;
        for (int i = 0; i < N_OUT; i++) e.outs[i] = (el >= POR_CYCLES + STAGE_GAP * i);
        e.busy    = ~&e.outs;
        e.cause   = cause_m;
        e.edge_no = edge_no;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit b, input bit s, input bit k);
        rst_n        = r;
        btn_n        = b;
        soft_rst_req = s;
        wdt_kick     = k | (auto_kick && (edge_no % 8 == 0));
        @(posedge CLK);
        model_edge(r, b, s, wdt_kick);
        @(negedge CLK);
    endtask

    task automatic run_to_run();
        for (int n = 0; n < 200 && !in_run; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (rst_out_n !== e.outs || busy !== e.busy || cause !== e.cause) begin
                    miscompares++;
                    $display("FAIL scoreboard edge %0d: rst_out_n=%b busy=%b cause=%0d, expected rst_out_n=%b busy=%b cause=%0d",
                             e.edge_no, rst_out_n, busy, cause, e.outs, e.busy, e.cause);
                end
            end
        end
    end

    initial begin : time_limit
        #2000000;
        $display("FAIL time_limit: simulation did not reach its summary");
        $fatal(1, "time limit expired");
    end

    initial begin : stimulus
        bit btn_lvl;
        int btn_left;
        int kick_pct;

        // Power-on: reset for 3 edges, then the staged release.
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_outs", 32'(rst_out_n), 0);
        check("reset_busy", 32'(busy), 1);
        repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("por_hold", 32'(rst_out_n), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("por_bit0", 32'(rst_out_n), 1);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("por_gap", 32'(rst_out_n), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("por_bit1", 32'(rst_out_n), 3);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("por_bit2", 32'(rst_out_n), 7);
        check("por_busy_low", 32'(busy), 0);
        check("por_cause", 32'(cause), 0);
        auto_kick = 1'b1;

        // Short bounce ignored; long press resets after sync + debounce.
        repeat (4)  step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("short_press", 32'(rst_out_n), 7);
        repeat (6)  step(1'b1, 1'b0, 1'b0, 1'b0);
        check("press_pre", 32'(rst_out_n), 7);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("press_reset", 32'(rst_out_n), 0);
        check("press_cause", 32'(cause), 1);
        repeat (13) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("press_held", 32'(rst_out_n), 0);
        run_to_run();
        check("press_rerelease", 32'(rst_out_n), 7);

        // Software reset from RUN, then a request during RELEASE is dropped.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("soft_reset", 32'(rst_out_n), 0);
        check("soft_cause", 32'(cause), 2);
        run_to_run();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (POR_CYCLES) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("soft_bit0", 32'(rst_out_n), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("soft_ignored", 32'(rst_out_n), 1);
        run_to_run();
        check("soft_complete", 32'(rst_out_n), 7);

        // Watchdog: regular kicks hold it off, silence trips it.
        auto_kick = 1'b0;
        for (int i = 0; i < 105; i++) step(1'b1, 1'b1, 1'b0, (i % 15) == 0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("wdt_kept", 32'(rst_out_n), 7);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("wdt_reset", 32'(rst_out_n), 0);
        check("wdt_cause", 32'(cause), 3);
        auto_kick = 1'b1;
        run_to_run();

        // Button beats a same-cycle soft request; rst_n aborts a RELEASE.
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("prio_reset", 32'(rst_out_n), 0);
        check("prio_cause", 32'(cause), 1);
        repeat (16) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("abort_pre", 32'(rst_out_n), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_outs", 32'(rst_out_n), 0);
        check("abort_cause", 32'(cause), 0);
        run_to_run();
        check("abort_restart", 32'(rst_out_n), 7);

        // Random traffic against the model.
        auto_kick = 1'b0;
        btn_lvl   = 1'b1;
        btn_left  = int'($urandom_range(20, 250));
        kick_pct  = 12;
        for (int n = 0; n < 2500; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0:       kick_pct = 0;
                    1:       kick_pct = 4;
                    2:       kick_pct = 12;
                    default: kick_pct = 40;
                endcase
            end
            if (btn_left == 0) begin
                btn_lvl  = ~btn_lvl;
                btn_left = btn_lvl ? int'($urandom_range(20, 250)) : int'($urandom_range(1, 25));
            end
            btn_left--;
            step($urandom_range(0, 599) != 0, btn_lvl,
                 $urandom_range(0, 39) == 0, int'($urandom_range(0, 99)) < kick_pct);
        end

        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter N_OUT, default 2: number of sequenced reset outputs, 1..8.
REQ-002 Parameter POR_CYCLES, default 8388608: hold cycles after any reset trigger before the first release, >=2.
REQ-003 Parameter STAGE_GAP, default 16: cycles between successive output releases, >=1.
REQ-004 Parameter DEBOUNCE_CYCLES, default 12000: consecutive stable samples needed to accept a button level change, >=1.
REQ-005 Parameter WDT_CYCLES, default 0: watchdog timeout in cycles; 0 disables the watchdog.
REQ-006 CLK  input  1  system clock.
REQ-007 rst_n  input  1  reset, synchronous, active-low; clock CLK.
REQ-008 btn_n  input  1  asynchronous pushbutton, active-low.
REQ-009 soft_rst_req  input  1  single-cycle software reset request.
REQ-010 wdt_kick  input  1  watchdog service pulse.
REQ-011 rst_out_n  output  N_OUT  per-domain reset, active-low; bit 0 releases first.
REQ-012 busy  output  1  high while any rst_out_n bit is low.
REQ-013 cause  output  2  last reset cause: 0 POR, 1 button, 2 software, 3 watchdog.

Function
REQ-014 btn_n shall pass through a 2-flop synchronizer; the debounced level shall change only after DEBOUNCE_CYCLES consecutive synchronized samples of the new level.
REQ-015 A button trigger shall be the debounced high-to-low transition; while debounced low, the FSM shall stay in HOLD with the hold counter cleared.
REQ-016 FSM states: HOLD, RELEASE, RUN.
REQ-017 HOLD: all rst_out_n low; counter increments each cycle; on the edge where the count reaches POR_CYCLES, rst_out_n[0] goes high and the FSM enters RELEASE (or RUN if N_OUT=1).
REQ-018 RELEASE: rst_out_n[i] goes high exactly STAGE_GAP*i cycles after rst_out_n[0]; on the edge releasing bit N_OUT-1, busy falls and the FSM enters RUN.
REQ-019 Released bits shall stay high until the next trigger; no bit shall release before a lower-index bit.
REQ-020 soft_rst_req shall be honoured only in RUN; in HOLD or RELEASE it shall be ignored, not queued.
REQ-021 Watchdog: counter active only in RUN and only when WDT_CYCLES>0; cleared on wdt_kick and on RUN entry; a trigger fires on the edge where the count reaches WDT_CYCLES without a kick.
REQ-022 Any trigger (button in any state; soft or watchdog in RUN) shall, on the next edge, drive all rst_out_n low, set busy, clear the hold counter, update cause and enter HOLD.
REQ-023 Simultaneous triggers: priority button > watchdog > software; cause records only the winner.
REQ-024 A button trigger during HOLD or RELEASE shall restart HOLD from zero and set cause=1.
REQ-025 Counter widths shall be sized from the parameters via $clog2 and shall not wrap within any defined count.

Reset
REQ-026 While rst_n is low at a CLK edge: rst_out_n all low, busy=1, cause=0, FSM=HOLD, all counters zero, debounced button = released (high), synchronizer flops high.
REQ-027 Counting shall start on the first edge at which rst_n is sampled high; rst_n asserted mid-sequence shall abort it identically to power-on.

Verification (N_OUT=3, POR_CYCLES=8, STAGE_GAP=4, DEBOUNCE_CYCLES=5, WDT_CYCLES=20)
REQ-028 rst_n low 3 cycles then high -> rst_out_n[0] rises on the 8th edge with rst_n high, [1] 4 edges later, [2] 8 edges later; busy falls with [2]; cause=0.
REQ-029 In RUN, btn_n low for 4 cycles then high -> no reset; btn_n low for 20 cycles -> all outputs low 2+5 edges after the falling edge, held while pressed, re-release sequence 8 edges after debounced release; cause=1.
REQ-030 In RUN, soft_rst_req pulse -> outputs low next edge, cause=2, full sequence; pulse during RELEASE -> ignored, sequence completes unchanged.
REQ-031 In RUN, kick every 15 cycles for 100 cycles -> no reset; stop kicking -> reset 20 edges after the last kick, cause=3.
REQ-032 Debounced button fall and soft_rst_req in the same cycle -> cause=1; rst_n pulsed low during RELEASE -> all outputs low, cause=0, sequence restarts from zero.
